// File: rtl/ctrl_seq.sv
// Multi-cycle control sequencer for the 8-bit CPU.
// Walks FETCH -> DECODE -> EX1..EX3 per instruction and decodes the IR opcode,
// zero flag and IN/OUT handshakes into every bus and register strobe.
// Strobes are combinational from state and inputs; state and the retired
// counter are the only registers. Reset forces every output low.
module ctrl_seq #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       opcode,
   input  logic             zero_flag,
   input  logic             out_ready,
   input  logic             in_valid,
   output logic             c_a,
   output logic             c_b,
   output logic             c_imm,
   output logic             gpr_oe,
   output logic             gpr_we,
   output logic             alu_lda,
   output logic             alu_ldb,
   output logic             alu_oe,
   output logic [2:0]       alu_op,
   output logic             flag_we,
   output logic             pc_inc,
   output logic             pc_ld,
   output logic             out_valid,
   output logic             in_ready,
   output logic             in_oe,
   output logic             halted,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EX1,
      S_EX2,
      S_EX3,
      S_HALT
   } state_t;

   localparam logic [2:0] ALU_ADD   = 3'b000;
   localparam logic [2:0] ALU_SUB   = 3'b001;
   localparam logic [2:0] ALU_PASSB = 3'b101;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state_q, state_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   logic             retire;

   // Strobe decode and next-state selection from state, opcode and handshakes.
   always_comb begin
      c_a       = 1'b0;
      c_b       = 1'b0;
      c_imm     = 1'b0;
      gpr_oe    = 1'b0;
      gpr_we    = 1'b0;
      alu_lda   = 1'b0;
      alu_ldb   = 1'b0;
      alu_oe    = 1'b0;
      alu_op    = ALU_ADD;
      flag_we   = 1'b0;
      pc_inc    = 1'b0;
      pc_ld     = 1'b0;
      out_valid = 1'b0;
      in_ready  = 1'b0;
      in_oe     = 1'b0;
      halted    = 1'b0;
      retire    = 1'b0;
      state_d   = state_q;

      case (state_q)
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: state_d = S_EX1;

         S_EX1: begin
            case (opcode)
               4'h1: begin
                  c_imm  = 1'b1;
                  c_a    = 1'b1;
                  gpr_we = 1'b1;
                  pc_inc = 1'b1;
                  retire = 1'b1;
               end
               4'h2: begin
                  c_b     = 1'b1;
                  gpr_oe  = 1'b1;
                  alu_ldb = 1'b1;
                  state_d = S_EX2;
               end
               4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8: begin
                  c_a     = 1'b1;
                  gpr_oe  = 1'b1;
                  alu_lda = 1'b1;
                  state_d = S_EX2;
               end
               4'h9: begin
                  c_imm  = 1'b1;
                  pc_ld  = 1'b1;
                  retire = 1'b1;
               end
               4'hA, 4'hB: begin
                  // JZ takes the branch on Z=1, JNZ on Z=0.
                  c_imm  = 1'b1;
                  pc_ld  = zero_flag ^ opcode[0];
                  pc_inc = ~(zero_flag ^ opcode[0]);
                  retire = 1'b1;
               end
               4'hC: begin
                  c_a       = 1'b1;
                  gpr_oe    = 1'b1;
                  out_valid = 1'b1;
                  pc_inc    = out_ready;
                  retire    = out_ready;
               end
               4'hD: begin
                  c_a      = 1'b1;
                  in_ready = 1'b1;
                  in_oe    = in_valid;
                  gpr_we   = in_valid;
                  pc_inc   = in_valid;
                  retire   = in_valid;
               end
               4'hF: begin
                  retire  = 1'b1;
                  state_d = S_HALT;
               end
               default: begin
                  pc_inc = 1'b1;
                  retire = 1'b1;
               end
            endcase
         end

         S_EX2: begin
            case (opcode)
               4'h2: begin
                  alu_op = ALU_PASSB;
                  alu_oe = 1'b1;
                  c_a    = 1'b1;
                  gpr_we = 1'b1;
                  pc_inc = 1'b1;
                  retire = 1'b1;
               end
               4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8: begin
                  c_b     = 1'b1;
                  gpr_oe  = 1'b1;
                  alu_ldb = 1'b1;
                  state_d = S_EX3;
               end
               default: state_d = S_FETCH;
            endcase
         end

         S_EX3: begin
            case (opcode)
               4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
                  // ADD..XOR occupy opcodes 3..7, ALU codes 0..4.
                  alu_op  = opcode[2:0] - 3'd3;
                  alu_oe  = 1'b1;
                  c_a     = 1'b1;
                  gpr_we  = 1'b1;
                  flag_we = 1'b1;
                  pc_inc  = 1'b1;
                  retire  = 1'b1;
               end
               4'h8: begin
                  alu_op  = ALU_SUB;
                  c_a     = 1'b1;
                  flag_we = 1'b1;
                  pc_inc  = 1'b1;
                  retire  = 1'b1;
               end
               default: state_d = S_FETCH;
            endcase
         end

         S_HALT:  halted = 1'b1;
         default: state_d = S_FETCH;
      endcase

      if (retire && (state_d != S_HALT)) begin
         state_d = S_FETCH;
      end
      retired_d = retire ? (retired_q + CNT_ONE) : retired_q;

      if (reset) begin
         c_a       = 1'b0;
         c_b       = 1'b0;
         c_imm     = 1'b0;
         gpr_oe    = 1'b0;
         gpr_we    = 1'b0;
         alu_lda   = 1'b0;
         alu_ldb   = 1'b0;
         alu_oe    = 1'b0;
         alu_op    = ALU_ADD;
         flag_we   = 1'b0;
         pc_inc    = 1'b0;
         pc_ld     = 1'b0;
         out_valid = 1'b0;
         in_ready  = 1'b0;
         in_oe     = 1'b0;
         halted    = 1'b0;
      end
   end

   // Sequencer state and retired-instruction counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_FETCH;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         retired_q <= retired_d;
      end
   end

   // Counter is forced low while reset is held.
   always_comb begin
      retired = reset ? '0 : retired_q;
   end

endmodule

// File: tb/tb_ctrl_seq.sv
// Self-checking bench for ctrl_seq: directed cases then random instruction
// streams, each checked cycle-by-cycle against per-instruction strobe tables.
module tb_ctrl_seq;

   localparam int unsigned CW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [3:0]    opcode;
   logic          zero_flag, out_ready, in_valid;
   logic          c_a, c_b, c_imm, gpr_oe, gpr_we, alu_lda, alu_ldb, alu_oe;
   logic [2:0]    alu_op;
   logic          flag_we, pc_inc, pc_ld, out_valid, in_ready, in_oe, halted;
   logic [CW-1:0] retired;

   ctrl_seq #(.CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .zero_flag(zero_flag),
      .out_ready(out_ready), .in_valid(in_valid),
      .c_a(c_a), .c_b(c_b), .c_imm(c_imm), .gpr_oe(gpr_oe), .gpr_we(gpr_we),
      .alu_lda(alu_lda), .alu_ldb(alu_ldb), .alu_oe(alu_oe), .alu_op(alu_op),
      .flag_we(flag_we), .pc_inc(pc_inc), .pc_ld(pc_ld), .out_valid(out_valid),
      .in_ready(in_ready), .in_oe(in_oe), .halted(halted), .retired(retired)
   );

   always #5 clk = ~clk;

   localparam logic [17:0] CA   = 18'h1 << 17;
   localparam logic [17:0] CB   = 18'h1 << 16;
   localparam logic [17:0] CIMM = 18'h1 << 15;
   localparam logic [17:0] GOE  = 18'h1 << 14;
   localparam logic [17:0] GWE  = 18'h1 << 13;
   localparam logic [17:0] LDA  = 18'h1 << 12;
   localparam logic [17:0] LDB  = 18'h1 << 11;
   localparam logic [17:0] AOE  = 18'h1 << 10;
   localparam logic [17:0] FWE  = 18'h1 << 6;
   localparam logic [17:0] PCI  = 18'h1 << 5;
   localparam logic [17:0] PCL  = 18'h1 << 4;
   localparam logic [17:0] OV   = 18'h1 << 3;
   localparam logic [17:0] IRDY = 18'h1 << 2;
   localparam logic [17:0] IOE  = 18'h1 << 1;
   localparam logic [17:0] HLT  = 18'h1;

   logic [17:0]   obs;
   assign obs = {c_a, c_b, c_imm, gpr_oe, gpr_we, alu_lda, alu_ldb, alu_oe,
                 alu_op, flag_we, pc_inc, pc_ld, out_valid, in_ready, in_oe, halted};

   int unsigned   checks = 0;
   int unsigned   errors = 0;
   logic [CW-1:0] model_ret = '0;

   function automatic logic [17:0] aluop(input int unsigned v);
      return 18'(v) << 7;
   endfunction

   // One clock cycle: drive inputs just after negedge, check, advance to next negedge.
   task automatic cyc(input logic [3:0] op, input logic z, input logic orv,
                      input logic ivv, input logic rst, input logic [17:0] exp,
                      input string tag);
      int unsigned drv;
      opcode = op; zero_flag = z; out_ready = orv; in_valid = ivv; reset = rst;
      #1;
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s strobes: got %h expected %h", tag, obs, exp);
      end
      checks++;
      assert (retired === (rst ? '0 : model_ret)) else begin
         errors++;
         $error("FAIL %s retired: got %0d expected %0d", tag, retired,
                rst ? 0 : model_ret);
      end
      drv = 32'(c_imm) + 32'(gpr_oe) + 32'(alu_oe) + 32'(in_oe);
      checks++;
      assert (drv <= 1 && !(c_a && c_b)) else begin
         errors++;
         $error("FAIL %s bus_excl: got drivers=%0d ca_cb=%b%b expected <=1 and not both",
                tag, drv, c_a, c_b);
      end
      @(negedge clk);
   endtask

   // Executes one whole instruction; stall = number of waiting handshake cycles.
   task automatic run_instr(input logic [3:0] op, input logic z, input int stall,
                            input string tag);
      logic [17:0] ex[$];
      logic        orv, ivv;
      ex = {};
      ex.push_back('0);
      ex.push_back('0);
      case (op)
         4'h1: ex.push_back(CIMM | CA | GWE | PCI);
         4'h2: begin
            ex.push_back(CB | GOE | LDB);
            ex.push_back(aluop(5) | AOE | CA | GWE | PCI);
         end
         4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
            ex.push_back(CA | GOE | LDA);
            ex.push_back(CB | GOE | LDB);
            ex.push_back(aluop(int'(op) - 3) | AOE | CA | GWE | FWE | PCI);
         end
         4'h8: begin
            ex.push_back(CA | GOE | LDA);
            ex.push_back(CB | GOE | LDB);
            ex.push_back(aluop(1) | CA | FWE | PCI);
         end
         4'h9: ex.push_back(CIMM | PCL);
         4'hA: ex.push_back(CIMM | (z ? PCL : PCI));
         4'hB: ex.push_back(CIMM | (z ? PCI : PCL));
         4'hC: begin
            for (int k = 0; k < stall; k++) ex.push_back(CA | GOE | OV);
            ex.push_back(CA | GOE | OV | PCI);
         end
         4'hD: begin
            for (int k = 0; k < stall; k++) ex.push_back(CA | IRDY);
            ex.push_back(CA | IRDY | IOE | GWE | PCI);
         end
         4'hF: ex.push_back('0);
         default: ex.push_back(PCI);
      endcase
      for (int i = 0; i < ex.size(); i++) begin
         orv = 1'($urandom);
         ivv = 1'($urandom);
         if (op == 4'hC && i >= 2) orv = (i - 2 == stall);
         if (op == 4'hD && i >= 2) ivv = (i - 2 == stall);
         cyc(op, z, orv, ivv, 1'b0, ex[i], tag);
      end
      model_ret = model_ret + 1'b1;
   endtask

   initial begin
      reset = 1'b1; opcode = 4'h1; zero_flag = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 3; i++) cyc(4'h1, 1'b1, 1'b1, 1'b1, 1'b1, '0, "reset");

      run_instr(4'h1, 1'b0, 0, "ldi");
      run_instr(4'h3, 1'b0, 0, "add");
      run_instr(4'h8, 1'b1, 0, "cmp");
      run_instr(4'h2, 1'b0, 0, "mov");
      run_instr(4'h7, 1'b0, 0, "xor");
      run_instr(4'hA, 1'b1, 0, "jz_t");
      run_instr(4'hA, 1'b0, 0, "jz_n");
      run_instr(4'hB, 1'b1, 0, "jnz_n");
      run_instr(4'hB, 1'b0, 0, "jnz_t");
      run_instr(4'h9, 1'b0, 0, "jmp");
      run_instr(4'hC, 1'b0, 4, "out_stall");
      run_instr(4'hD, 1'b0, 2, "in_stall");
      run_instr(4'hE, 1'b0, 0, "rsvd");
      run_instr(4'h0, 1'b0, 0, "nop");

      // Random stream; CNT_W=4 so the counter wraps several times.
      for (int n = 0; n < 80; n++) begin
         run_instr(4'($urandom_range(0, 14)), 1'($urandom), int'($urandom_range(0, 3)),
                   "rand");
      end

      // Reset asserted during EX2 of an ADD.
      cyc(4'h3, 1'b0, 1'b0, 1'b0, 1'b0, '0, "mid_fetch");
      cyc(4'h3, 1'b0, 1'b0, 1'b0, 1'b0, '0, "mid_decode");
      cyc(4'h3, 1'b0, 1'b0, 1'b0, 1'b0, CA | GOE | LDA, "mid_ex1");
      cyc(4'h3, 1'b0, 1'b0, 1'b0, 1'b1, '0, "mid_ex2_reset");
      model_ret = '0;
      run_instr(4'h3, 1'b0, 0, "after_reset");
      run_instr(4'h4, 1'b1, 0, "sub");

      run_instr(4'hF, 1'b0, 0, "hlt");
      for (int i = 0; i < 100; i++) begin
         cyc(4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0, HLT, "halted");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
